byte_en_ram_pipelined: RTL and testbench
========================================

BYTE_EN_RAM_PIPELINED -- requirements
Module: byte_en_ram_pipelined

Interface
REQ-001 Parameter DATA_WIDTH, default XLEN, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter LINES, default 4096, depth in words; SHALL be a power of two, at least 2.
REQ-003 Parameter READ_LATENCY, default 1, cycles from enable to read data; SHALL be 1 or 2.
REQ-004 Parameter WRITE_MODE, default RAM_READ_FIRST, same-cycle read behaviour; values RAM_READ_FIRST or RAM_WRITE_FIRST.
REQ-005 Parameter CLEAR_ON_RESET, default 1, zero-fill memory after reset when 1.
REQ-006 Ports, in order:
- clk  in  1  clock; one clock domain only.
- rst_n  in  1  asynchronous, active-low reset.
- a_en / b_en  in  1  port access enable.
- a_be / b_be  in  DATA_WIDTH/8  byte write enables; all zero means read.
- a_addr / b_addr  in  clog2(LINES)  word address.
- a_wdata / b_wdata  in  DATA_WIDTH  write data.
- a_rdata / b_rdata  out  DATA_WIDTH  read data.
- a_rvalid / b_rvalid  out  1  read data valid strobe.
- init_done  out  1  memory is usable.
- collision  out  1  one-cycle pulse for a same-address access.

Function
REQ-007 FSM states: CLEAR and READY. Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise READY.
REQ-008 CLEAR: counter starts at 0 and writes zero to one line per cycle. After line LINES-1 is written, the FSM moves to READY on the next cycle. Total: exactly LINES cycles.
REQ-009 In CLEAR, init_done=0 and port enables are ignored: no writes, no rvalid. In READY, init_done=1.
REQ-010 Every enabled access returns data: xN_rvalid=1 exactly READ_LATENCY cycles after the enable cycle, with xN_rdata alongside it.
REQ-011 The write happens in the enable cycle, only for bytes with be=1. The accessing port's own rdata follows WRITE_MODE: READ_FIRST returns old bytes; WRITE_FIRST returns the merged new word.
REQ-012 xN_rdata holds its last value while rvalid=0.
REQ-013 READ_LATENCY=2 adds one output register stage. The pipeline is fully pipelined: one access per port per cycle, back-to-back, no stalls.
REQ-014 Collision is both ports enabled, same address, same READY cycle, at least one port writing. The collision pulse is asserted the following cycle.
REQ-015 Collision with both ports writing: stored bytes come from A where a_be=1, from B where only b_be=1, and are unchanged elsewhere.
REQ-016 Collision with one port reading: the reader's data follows WRITE_MODE. READ_FIRST gives the old word; WRITE_FIRST gives the word after the REQ-015 merge. Both ports see the same word.
REQ-017 No collision when both ports only read or addresses differ. Both ports reading one address return identical data.
REQ-018 Address wrap is not applicable: the full address range is legal, with no out-of-range handling.

Reset
REQ-019 rst_n low asynchronously clears: rdata=0, rvalid=0, collision=0, init_done=0, clear counter=0, and all pipeline valid bits.
REQ-020 Reset mid-CLEAR restarts the sweep at line 0. Reset mid-pipeline drops in-flight reads: no rvalid after reset release for accesses issued before reset.
REQ-021 Memory contents are not reset; only the CLEAR sweep zeroes them.

Structure
REQ-022 Enum ram_write_mode_t {RAM_READ_FIRST, RAM_WRITE_FIRST} SHALL live in taiga_types.
REQ-023 The storage array and raw per-port read/write SHALL be the sub-module byte_en_ram_core; it has no reset and is vendor-inferable.
REQ-024 The top level holds the CLEAR FSM, collision detect/merge, forwarding mux and output pipeline.

Verification
REQ-025 LINES=16, CLEAR_ON_RESET=1: release reset → init_done rises after 16 cycles; reading all 16 lines returns 0.
REQ-026 READ_LATENCY=2: write 0xDEADBEEF to line 3 (be=0xF), then b_be=0x2 with 0x0000AA00 → read line 3 two cycles later returns 0xDEADAAEF.
REQ-027 Both ports write line 5: a_be=0x3 with 0x11111111, b_be=0xF with 0x22222222 → line 5=0x22221111; collision pulses 1 cycle.
REQ-028 Line 7=0x0, A writes 0xFFFFFFFF while B reads line 7 → READ_FIRST: b_rdata=0x0; WRITE_FIRST: b_rdata=0xFFFFFFFF.
REQ-029 rst_n pulsed low at cycle 8 of CLEAR → sweep restarts; init_done rises LINES cycles after release; no stray rvalid.

Source files
------------

// File: rtl/taiga_types.sv
// rtl/taiga_types.sv - shared types for the byte-enable RAM block
package taiga_types;

  localparam int XLEN = 32;

  // Same-cycle read behaviour of a port that is also being written
  typedef enum logic {
    RAM_READ_FIRST,
    RAM_WRITE_FIRST
  } ram_write_mode_t;

  // Power-up sweep state of the RAM wrapper
  typedef enum logic {
    CLEAR,
    READY
  } ram_init_state_t;

endpackage

// File: rtl/byte_en_ram_core.sv
// rtl/byte_en_ram_core.sv - dual-port byte-enable storage array, read-first raw ports
module byte_en_ram_core #(
  parameter int DATA_WIDTH = 32,
  parameter int LINES = 4096,
  localparam int NB = DATA_WIDTH / 8,
  localparam int AW = $clog2(LINES)
) (
  input  logic                  clk,
  input  logic                  a_en,
  input  logic [NB-1:0]         a_be,
  input  logic [AW-1:0]         a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_q,
  input  logic                  b_en,
  input  logic [NB-1:0]         b_be,
  input  logic [AW-1:0]         b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic [DATA_WIDTH-1:0] b_q
);

  logic [DATA_WIDTH-1:0] mem [LINES];

  // Byte writes then registered reads of the pre-write word; A is applied last so it owns shared bytes
  always_ff @(posedge clk) begin
    if (b_en) begin
      for (int i = 0; i < NB; i++) begin
        if (b_be[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
      end
    end
    if (a_en) begin
      for (int i = 0; i < NB; i++) begin
        if (a_be[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
    if (a_en) a_q <= mem[a_addr];
    if (b_en) b_q <= mem[b_addr];
  end

endmodule

// File: rtl/byte_en_ram_pipelined.sv
// rtl/byte_en_ram_pipelined.sv - dual-port byte-enable RAM with clear sweep, collision merge and read pipeline
module byte_en_ram_pipelined
  import taiga_types::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int LINES = 4096,
  parameter int READ_LATENCY = 1,
  parameter ram_write_mode_t WRITE_MODE = RAM_READ_FIRST,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int NB = DATA_WIDTH / 8,
  localparam int AW = $clog2(LINES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_en,
  input  logic                  b_en,
  input  logic [NB-1:0]         a_be,
  input  logic [NB-1:0]         b_be,
  input  logic [AW-1:0]         a_addr,
  input  logic [AW-1:0]         b_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic                  init_done,
  output logic                  collision
);

  function automatic logic [DATA_WIDTH-1:0] merge_be(input logic [DATA_WIDTH-1:0] old_word,
                                                    input logic [DATA_WIDTH-1:0] wdata,
                                                    input logic [NB-1:0]         be);
    logic [DATA_WIDTH-1:0] w;
    w = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
    end
    return w;
  endfunction

  ram_init_state_t state, next_state;
  logic [AW-1:0] clr_cnt;
  logic          clear_we;
  logic          ready;

  logic                  a_acc, b_acc, same_now, coll_now;
  logic                  core_a_en;
  logic [NB-1:0]         core_a_be;
  logic [AW-1:0]         core_a_addr;
  logic [DATA_WIDTH-1:0] core_a_wdata;
  logic [DATA_WIDTH-1:0] a_q, b_q;

  logic                  s1_a_valid, s1_b_valid, s1_same;
  logic [NB-1:0]         s1_a_be, s1_b_be;
  logic [DATA_WIDTH-1:0] s1_a_wdata, s1_b_wdata;
  logic [DATA_WIDTH-1:0] both_word, a_new, b_new, a_word, b_word;
  logic [DATA_WIDTH-1:0] a_last, b_last;

  // Sweep state, line counter and the registered usable flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR_ON_RESET ? CLEAR : READY;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= next_state;
      init_done <= (next_state == READY);
      if (clear_we) clr_cnt <= clr_cnt + AW'(1);
    end
  end

  // Zero one line per cycle in CLEAR, leave after the last line
  always_comb begin
    next_state = state;
    clear_we   = 1'b0;
    ready      = 1'b0;
    case (state)
      CLEAR: begin
        clear_we = 1'b1;
        if (clr_cnt == AW'(LINES - 1)) next_state = READY;
      end
      READY:   ready = 1'b1;
      default: next_state = READY;
    endcase
  end

  assign a_acc    = ready & a_en;
  assign b_acc    = ready & b_en;
  assign same_now = a_acc & b_acc & (a_addr == b_addr);
  assign coll_now = same_now & ((|a_be) | (|b_be));

  // The sweep borrows port A; user traffic is blocked until READY
  always_comb begin
    core_a_en    = a_acc;
    core_a_be    = a_be;
    core_a_addr  = a_addr;
    core_a_wdata = a_wdata;
    if (clear_we) begin
      core_a_en    = 1'b1;
      core_a_be    = '1;
      core_a_addr  = clr_cnt;
      core_a_wdata = '0;
    end
  end

  byte_en_ram_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .LINES     (LINES)
  ) u_core (
    .clk    (clk),
    .a_en   (core_a_en),
    .a_be   (core_a_be),
    .a_addr (core_a_addr),
    .a_wdata(core_a_wdata),
    .a_q    (a_q),
    .b_en   (b_acc),
    .b_be   (b_be),
    .b_addr (b_addr),
    .b_wdata(b_wdata),
    .b_q    (b_q)
  );

  // First-stage valids and the one-cycle collision pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_valid <= 1'b0;
      s1_b_valid <= 1'b0;
      collision  <= 1'b0;
    end else begin
      s1_a_valid <= a_acc;
      s1_b_valid <= b_acc;
      collision  <= coll_now;
    end
  end

  // Write info travelling with each access; only consumed alongside its valid bit
  always_ff @(posedge clk) begin
    s1_a_be    <= a_be;
    s1_a_wdata <= a_wdata;
    s1_b_be    <= b_be;
    s1_b_wdata <= b_wdata;
    s1_same    <= same_now;
  end

  // Rebuild the post-write word from the raw old word; on a shared line A wins its bytes
  always_comb begin
    both_word = merge_be(merge_be(a_q, s1_b_wdata, s1_b_be), s1_a_wdata, s1_a_be);
    a_new     = s1_same ? both_word : merge_be(a_q, s1_a_wdata, s1_a_be);
    b_new     = s1_same ? both_word : merge_be(b_q, s1_b_wdata, s1_b_be);
    a_word    = (WRITE_MODE == RAM_WRITE_FIRST) ? a_new : a_q;
    b_word    = (WRITE_MODE == RAM_WRITE_FIRST) ? b_new : b_q;
  end

  // Last returned word per port, held while no read is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_last <= '0;
      b_last <= '0;
    end else begin
      if (s1_a_valid) a_last <= a_word;
      if (s1_b_valid) b_last <= b_word;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic a_v2, b_v2;

      // Extra output stage: valid follows the registered word by one cycle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_v2 <= 1'b0;
          b_v2 <= 1'b0;
        end else begin
          a_v2 <= s1_a_valid;
          b_v2 <= s1_b_valid;
        end
      end

      assign a_rvalid = a_v2;
      assign b_rvalid = b_v2;
      assign a_rdata  = a_last;
      assign b_rdata  = b_last;
    end else begin : g_lat1
      assign a_rvalid = s1_a_valid;
      assign b_rvalid = s1_b_valid;
      assign a_rdata  = s1_a_valid ? a_word : a_last;
      assign b_rdata  = s1_b_valid ? b_word : b_last;
    end
  endgenerate

endmodule

// File: tb/tb_byte_en_ram_pipelined.sv
// tb/tb_byte_en_ram_pipelined.sv - scoreboard bench for byte_en_ram_pipelined
module tb_byte_en_ram_pipelined;
  import taiga_types::*;

  localparam int DW = 32;
  localparam int LN = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_en, b_en;
  logic [3:0]    a_be, b_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;

  logic [DW-1:0] a_rdata0, b_rdata0, a_rdata1, b_rdata1;
  logic          a_rvalid0, b_rvalid0, a_rvalid1, b_rvalid1;
  logic          init_done0, init_done1, collision0, collision1;

  byte_en_ram_pipelined #(
    .DATA_WIDTH(DW), .LINES(LN), .READ_LATENCY(1),
    .WRITE_MODE(RAM_READ_FIRST), .CLEAR_ON_RESET(1'b1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .b_en(b_en), .a_be(a_be), .b_be(b_be),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_rdata(a_rdata0), .b_rdata(b_rdata0), .a_rvalid(a_rvalid0), .b_rvalid(b_rvalid0),
    .init_done(init_done0), .collision(collision0)
  );

  byte_en_ram_pipelined #(
    .DATA_WIDTH(DW), .LINES(LN), .READ_LATENCY(2),
    .WRITE_MODE(RAM_WRITE_FIRST), .CLEAR_ON_RESET(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .b_en(b_en), .a_be(a_be), .b_be(b_be),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_rdata(a_rdata1), .b_rdata(b_rdata1), .a_rvalid(a_rvalid1), .b_rvalid(b_rvalid1),
    .init_done(init_done1), .collision(collision1)
  );

  // channels: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B
  logic [DW-1:0] rd [4];
  logic          rv [4];
  assign rd[0] = a_rdata0;
  assign rd[1] = b_rdata0;
  assign rd[2] = a_rdata1;
  assign rd[3] = b_rdata1;
  assign rv[0] = a_rvalid0;
  assign rv[1] = b_rvalid0;
  assign rv[2] = a_rvalid1;
  assign rv[3] = b_rvalid1;

  typedef struct {
    int          c;
    logic [31:0] d;
  } exp_t;

  exp_t        expq [4][$];
  bit          coll_exp [int];
  logic [31:0] mem [LN];
  logic [31:0] last [4];
  bit          ready;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; when the RAM is usable, the reference model predicts the results
  task automatic issue(input logic ae, input logic [3:0] abe, input logic [3:0] aad, input logic [31:0] awd,
                       input logic be_, input logic [3:0] bbe, input logic [3:0] bad, input logic [31:0] bwd);
    logic [31:0] nm [LN];
    a_en = ae; a_be = abe; a_addr = aad; a_wdata = awd;
    b_en = be_; b_be = bbe; b_addr = bad; b_wdata = bwd;
    if (ready) begin
      nm = mem;
      for (int i = 0; i < 4; i++) begin
        if (ae && abe[i]) nm[aad][8*i +: 8] = awd[8*i +: 8];
        if (be_ && bbe[i] && !(ae && aad == bad && abe[i])) nm[bad][8*i +: 8] = bwd[8*i +: 8];
      end
      if (ae) begin
        expq[0].push_back('{cyc + 1, mem[aad]});
        expq[2].push_back('{cyc + 2, nm[aad]});
      end
      if (be_) begin
        expq[1].push_back('{cyc + 1, mem[bad]});
        expq[3].push_back('{cyc + 2, nm[bad]});
      end
      if (ae && be_ && aad == bad && (abe != 4'h0 || bbe != 4'h0)) coll_exp[cyc + 1] = 1'b1;
      mem = nm;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic issue_rand(input int addr_max);
    logic [3:0] abe, bbe;
    abe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    bbe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    issue(($urandom_range(0, 3) != 0), abe, 4'($urandom_range(0, addr_max)), $urandom,
          ($urandom_range(0, 3) != 0), bbe, 4'($urandom_range(0, addr_max)), $urandom);
  endtask

  // Sweep length after reset release, with junk traffic that must be ignored meanwhile
  task automatic wait_init();
    int k;
    k = 0;
    do begin
      issue_rand(15);
      k++;
    end while (!init_done0 && k < 100);
    chk("init_latency", 32'(k), 32'd16);
    chk("init_done_dut1", 32'(init_done1), 32'd1);
    for (int i = 0; i < LN; i++) mem[i] = 32'h0;
    ready = 1'b1;
  endtask

  // Monitor: reset values, scoreboard pops, hold behaviour and collision pulses
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 4; ch++) begin
        chk($sformatf("reset_rvalid%0d", ch), 32'(rv[ch]), 32'd0);
        chk($sformatf("reset_rdata%0d", ch), rd[ch], 32'h0);
        expq[ch].delete();
        last[ch] = 32'h0;
      end
      chk("reset_collision0", 32'(collision0), 32'd0);
      chk("reset_collision1", 32'(collision1), 32'd0);
      chk("reset_init_done0", 32'(init_done0), 32'd0);
      chk("reset_init_done1", 32'(init_done1), 32'd0);
      coll_exp.delete();
    end else begin
      for (int ch = 0; ch < 4; ch++) begin
        if (rv[ch]) begin
          if (expq[ch].size() == 0) begin
            chk($sformatf("stray_rvalid%0d", ch), 32'(rv[ch]), 32'd0);
          end else begin
            mon_e = expq[ch].pop_front();
            chk($sformatf("rvalid_cycle%0d", ch), 32'(cyc), 32'(mon_e.c));
            chk($sformatf("rdata%0d", ch), rd[ch], mon_e.d);
            last[ch] = mon_e.d;
          end
        end else begin
          chk($sformatf("rdata_hold%0d", ch), rd[ch], last[ch]);
          if (expq[ch].size() > 0 && expq[ch][0].c <= cyc) begin
            chk($sformatf("missing_rvalid%0d", ch), 32'(rv[ch]), 32'd1);
            void'(expq[ch].pop_front());
          end
        end
      end
      chk("collision0", 32'(collision0), 32'(coll_exp.exists(cyc)));
      chk("collision1", 32'(collision1), 32'(coll_exp.exists(cyc)));
    end
  end

  initial begin
    ready = 1'b0;
    a_en = 1'b0; a_be = 4'h0; a_addr = '0; a_wdata = '0;
    b_en = 1'b0; b_be = 4'h0; b_addr = '0; b_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init();

    // freshly swept memory reads back as zero on both ports
    for (int i = 0; i < LN; i++) issue(1'b1, 4'h0, 4'(i), $urandom, 1'b1, 4'h0, 4'(15 - i), $urandom);

    // partial byte write over a full word
    issue(1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 1'b0, 4'h0, 4'd0, 32'h0);
    issue(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h2, 4'd3, 32'h0000AA00);
    issue(1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    idle();
    chk("partial_write_lat2", rd[2], 32'hDEADAAEF);
    chk("partial_write_lat1", rd[0], 32'hDEADAAEF);

    // both ports write the same line
    issue(1'b1, 4'h3, 4'd5, 32'h11111111, 1'b1, 4'hF, 4'd5, 32'h22222222);
    chk("dual_write_collision", 32'(collision0), 32'd1);
    idle();
    chk("dual_write_pulse_end", 32'(collision1), 32'd0);
    issue(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    idle();
    chk("dual_write_merge_lat2", rd[2], 32'h22221111);
    chk("dual_write_merge_lat1", rd[0], 32'h22221111);

    // write on A while B reads the same line
    issue(1'b1, 4'hF, 4'd7, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    issue(1'b1, 4'hF, 4'd7, 32'hFFFFFFFF, 1'b1, 4'h0, 4'd7, 32'h0);
    idle();
    chk("read_first_b", rd[1], 32'h0);
    chk("write_first_b", rd[3], 32'hFFFFFFFF);

    // random traffic, narrow address range to provoke collisions, then full range
    repeat (300) issue_rand(3);
    repeat (200) issue_rand(15);

    // reset with reads still in flight
    repeat (3) issue(1'b1, 4'h0, 4'($urandom_range(0, 15)), 32'h0, 1'b1, 4'h0, 4'($urandom_range(0, 15)), 32'h0);
    rst_n = 1'b0;
    ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;

    // reset again part-way through the sweep
    repeat (8) issue_rand(15);
    #2;
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    wait_init();

    for (int i = 0; i < LN; i++) issue(1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 4'h0, 4'(i), 32'h0);
    repeat (100) issue_rand(7);
    repeat (4) idle();
    for (int ch = 0; ch < 4; ch++) chk($sformatf("drained%0d", ch), 32'(expq[ch].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
